// File: rtl/tilt_ball_logic.sv
// Tilt-controlled ball: moves a square ball by a saturated accelerometer step once per action period
// and renders ball-over-background pixels for the VGA DAC. Optional wall flash: define WALL_FLASH_EN.
module tilt_ball_logic #(
  parameter int          COORD_W           = 10,
  parameter int          H_ACTIVE          = 800,
  parameter int          V_ACTIVE          = 600,
  parameter int          FRAMES_PER_ACTION = 2,
  parameter logic [7:0]  ACCEL_X_CORR      = 8'd3,
  parameter logic [7:0]  ACCEL_Y_CORR      = 8'd1,
  parameter int          ACCEL_SHIFT       = 2,
  parameter int          MAX_STEP          = 8,
  parameter int          BALL_SIZE         = 16,
  parameter logic [11:0] BALL_RGB          = 12'hF00,
  parameter int          FLASH_FRAMES      = 8
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               button_c,
  input  logic [7:0]         accel_data_x,
  input  logic [7:0]         accel_data_y,
  input  logic [COORD_W-1:0] h_coord,
  input  logic [COORD_W-1:0] v_coord,
  input  logic [2:0]         SW,
  output logic [7:0]         accel_x_end_of_frame,
  output logic [7:0]         accel_y_end_of_frame,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               action_stb,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int NW = COORD_W + 2;
  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(H_ACTIVE - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(V_ACTIVE - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_HOME = COORD_W'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_HOME = COORD_W'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W:0]   H_END  = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0]   V_END  = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0]   B_EXT  = (COORD_W+1)'(BALL_SIZE);
  localparam int CNT_W = (FRAMES_PER_ACTION > 1) ? $clog2(FRAMES_PER_ACTION) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_ACTION - 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  localparam logic signed [NW-1:0] STEP_HI = NW'(MAX_STEP);
  localparam logic signed [NW-1:0] STEP_LO = -STEP_HI;

  // Corrected accel, arithmetic shift, then saturate to +/-MAX_STEP.
  function automatic logic signed [NW-1:0] tilt_step(input logic [7:0] corr);
    logic signed [7:0]    shifted;
    logic signed [NW-1:0] wide;
    shifted = $signed(corr) >>> ACCEL_SHIFT;
    wide    = {{(NW-8){shifted[7]}}, shifted};
    if (wide > STEP_HI)      tilt_step = STEP_HI;
    else if (wide < STEP_LO) tilt_step = STEP_LO;
    else                     tilt_step = wide;
  endfunction

  function automatic logic [COORD_W-1:0] clamp_pos(input logic signed [NW-1:0] nxt,
                                                   input logic [COORD_W-1:0]  lim);
    if (nxt[NW-1])                          clamp_pos = '0;
    else if (nxt > $signed({2'b00, lim}))   clamp_pos = lim;
    else                                    clamp_pos = nxt[COORD_W-1:0];
  endfunction

  logic             eof;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       btn_sync;
  logic             tick;

  logic [7:0]           corr_x, corr_y;
  logic signed [NW-1:0] next_x, next_y;
  logic [COORD_W-1:0]   clamp_x, clamp_y;

  assign tick    = eof && (frame_cnt == CNT_LAST);
  assign corr_x  = accel_data_x + ACCEL_X_CORR;
  assign corr_y  = accel_data_y + ACCEL_Y_CORR;
  assign next_x  = $signed({2'b00, ball_x}) + tilt_step(corr_x);
  assign next_y  = $signed({2'b00, ball_y}) + tilt_step(corr_y);
  assign clamp_x = clamp_pos(next_x, X_MAX);
  assign clamp_y = clamp_pos(next_y, Y_MAX);

  // The tick follows the last active pixel, so the ball only moves during blanking.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      eof                  <= 1'b0;
      frame_cnt            <= '0;
      btn_sync             <= 2'b00;
      action_stb           <= 1'b0;
      accel_x_end_of_frame <= 8'd0;
      accel_y_end_of_frame <= 8'd0;
      ball_x               <= X_HOME;
      ball_y               <= Y_HOME;
    end else begin
      eof        <= (h_coord == H_LAST) && (v_coord == V_LAST);
      btn_sync   <= {btn_sync[0], button_c};
      action_stb <= tick;
      if (eof) frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      if (tick) begin
        accel_x_end_of_frame <= corr_x;
        accel_y_end_of_frame <= corr_y;
        if (btn_sync[1]) begin
          ball_x <= X_HOME;
          ball_y <= Y_HOME;
        end else begin
          ball_x <= clamp_x;
          ball_y <= clamp_y;
        end
      end
    end
  end

`ifdef WALL_FLASH_EN
  logic               wall_hit;
  logic [FLASH_W-1:0] flash_cnt;

  assign wall_hit = !btn_sync[1] &&
                    (next_x[NW-1] || (next_x > $signed({2'b00, X_MAX})) ||
                     next_y[NW-1] || (next_y > $signed({2'b00, Y_MAX})));

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)                          flash_cnt <= '0;
    else if (tick && wall_hit)           flash_cnt <= FLASH_W'(FLASH_FRAMES);
    else if (eof && (flash_cnt != '0))   flash_cnt <= flash_cnt - 1'b1;
  end
`else
  logic [FLASH_W-1:0] flash_cnt;
  assign flash_cnt = '0;
`endif

  logic [COORD_W:0] h_ext, v_ext, bx_end, by_end;
  logic             active, in_ball;
  logic [2:0]       bg;

  assign h_ext   = {1'b0, h_coord};
  assign v_ext   = {1'b0, v_coord};
  assign bx_end  = {1'b0, ball_x} + B_EXT;
  assign by_end  = {1'b0, ball_y} + B_EXT;
  assign active  = (h_ext < H_END) && (v_ext < V_END);
  assign in_ball = (h_coord >= ball_x) && (h_ext < bx_end) &&
                   (v_coord >= ball_y) && (v_ext < by_end);
  assign bg      = (flash_cnt != '0) ? ~SW : SW;

  // SW is {b,g,r}; each enabled channel is driven full scale.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (!active) begin
      red   <= 4'h0;
      green <= 4'h0;
      blue  <= 4'h0;
    end else if (in_ball) begin
      {red, green, blue} <= BALL_RGB;
    end else begin
      red   <= {4{bg[0]}};
      green <= {4{bg[1]}};
      blue  <= {4{bg[2]}};
    end
  end

endmodule

// File: tb/tb_tilt_ball_logic.sv
// Directed bench for tilt_ball_logic: frames are synthesised by driving h/v to the last active pixel.
module tb_tilt_ball_logic;

`ifdef WALL_FLASH_EN
  localparam bit FLASH_ON = 1'b1;
`else
  localparam bit FLASH_ON = 1'b0;
`endif

  logic       pixel_clk;
  logic       rst_n;
  logic       button_c;
  logic [7:0] accel_data_x, accel_data_y;
  logic [9:0] h_coord, v_coord;
  logic [2:0] SW;
  logic [7:0] accel_x_end_of_frame, accel_y_end_of_frame;
  logic [9:0] ball_x, ball_y;
  logic       action_stb;
  logic [3:0] red, green, blue;

  int checks = 0;
  int failures = 0;

  // expected {ball_x, ball_y, accel_x_eof, accel_y_eof}
  logic [35:0] exp_q[$];
  logic [11:0] rgb_q[$];

  int mdl_x = 392;
  int mdl_y = 292;
  int mdl_flash = 0;

  tilt_ball_logic dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .button_c(button_c),
    .accel_data_x(accel_data_x), .accel_data_y(accel_data_y),
    .h_coord(h_coord), .v_coord(v_coord), .SW(SW),
    .accel_x_end_of_frame(accel_x_end_of_frame), .accel_y_end_of_frame(accel_y_end_of_frame),
    .ball_x(ball_x), .ball_y(ball_y), .action_stb(action_stb),
    .red(red), .green(green), .blue(blue)
  );

  // clock / watchdog
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_step(input logic [7:0] raw, input logic [7:0] c);
    logic [7:0] s8;
    int v;
    int q;
    s8 = raw + c;
    v  = int'($signed(s8));
    q  = (v < 0) ? -((-v + 3) / 4) : v / 4;
    if (q > 8) q = 8;
    if (q < -8) q = -8;
    return q;
  endfunction

  task automatic eof_pulse();
    h_coord = 10'd799;
    v_coord = 10'd599;
    @(negedge pixel_clk);
    h_coord = 10'd0;
    v_coord = 10'd0;
    @(negedge pixel_clk);
  endtask

  task automatic flash_eof(input logic hit);
    if (FLASH_ON && hit) mdl_flash = 8;
    else if (mdl_flash > 0) mdl_flash--;
  endtask

  task automatic do_action(input logic [7:0] ax, input logic [7:0] ay, input logic btn);
    int nx, ny;
    logic hit;
    logic [7:0] cx, cy;
    logic [35:0] e;
    accel_data_x = ax;
    accel_data_y = ay;
    button_c = btn;
    repeat (3) @(negedge pixel_clk);
    cx = ax + 8'd3;
    cy = ay + 8'd1;
    hit = 1'b0;
    if (btn) begin
      nx = 392;
      ny = 292;
    end else begin
      nx = mdl_x + sat_step(ax, 8'd3);
      ny = mdl_y + sat_step(ay, 8'd1);
      if (nx < 0)   begin nx = 0;   hit = 1'b1; end
      if (nx > 784) begin nx = 784; hit = 1'b1; end
      if (ny < 0)   begin ny = 0;   hit = 1'b1; end
      if (ny > 584) begin ny = 584; hit = 1'b1; end
    end
    exp_q.push_back({10'(nx), 10'(ny), cx, cy});
    eof_pulse();
    chk("stb_first_eof", {35'd0, action_stb}, 36'd0);
    flash_eof(1'b0);
    eof_pulse();
    chk("stb_action", {35'd0, action_stb}, 36'd1);
    flash_eof(hit);
    e = exp_q.pop_front();
    chk("ball_x", {26'd0, ball_x}, {26'd0, e[35:26]});
    chk("ball_y", {26'd0, ball_y}, {26'd0, e[25:16]});
    chk("accel_x_eof", {28'd0, accel_x_end_of_frame}, {28'd0, e[15:8]});
    chk("accel_y_eof", {28'd0, accel_y_end_of_frame}, {28'd0, e[7:0]});
    mdl_x = nx;
    mdl_y = ny;
    @(negedge pixel_clk);
    chk("stb_one_cycle", {35'd0, action_stb}, 36'd0);
    button_c = 1'b0;
  endtask

  task automatic render(input int h, input int v, input logic [2:0] sw);
    logic [2:0]  bg;
    logic [11:0] e;
    h_coord = 10'(h);
    v_coord = 10'(v);
    SW = sw;
    bg = (mdl_flash > 0) ? ~sw : sw;
    if (h >= 800 || v >= 600) e = 12'h000;
    else if (h >= mdl_x && h < mdl_x + 16 && v >= mdl_y && v < mdl_y + 16) e = 12'hF00;
    else e = {bg[0] ? 4'hF : 4'h0, bg[1] ? 4'hF : 4'h0, bg[2] ? 4'hF : 4'h0};
    rgb_q.push_back(e);
    @(negedge pixel_clk);
    chk("rgb", {24'd0, red, green, blue}, {24'd0, rgb_q.pop_front()});
    h_coord = 10'd0;
    v_coord = 10'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    mdl_x = 392;
    mdl_y = 292;
    mdl_flash = 0;
    repeat (2) @(negedge pixel_clk);
    chk("rst_ball_x", {26'd0, ball_x}, 36'd392);
    chk("rst_ball_y", {26'd0, ball_y}, 36'd292);
    chk("rst_rgb", {24'd0, red, green, blue}, 36'd0);
    chk("rst_stb", {35'd0, action_stb}, 36'd0);
    chk("rst_accel_x", {28'd0, accel_x_end_of_frame}, 36'd0);
    rst_n = 1'b1;
    @(negedge pixel_clk);
  endtask

  initial begin
    button_c = 1'b0;
    accel_data_x = 8'd0;
    accel_data_y = 8'd0;
    h_coord = 10'd0;
    v_coord = 10'd0;
    SW = 3'b000;
    apply_reset();

    // render: background, ball interior, edges, blanking
    render(0, 0, 3'b101);
    render(395, 295, 3'b101);
    render(810, 10, 3'b101);
    render(10, 600, 3'b111);
    render(391, 292, 3'b010);
    render(408, 292, 3'b010);
    render(407, 307, 3'b010);
    render(392, 308, 3'b001);

    // basic tilt and saturation in both directions
    do_action(8'd29, 8'hFF, 1'b0);
    do_action(8'd100, 8'd0, 1'b0);
    do_action(8'h9C, 8'd0, 1'b0);
    do_action(8'd0, 8'd100, 1'b0);
    do_action(8'd0, 8'h9C, 1'b0);

    // walk right to the wall, land on 780, then clamp
    while (mdl_x < 776) do_action(8'd100, 8'hFF, 1'b0);
    do_action(8'd13, 8'hFF, 1'b0);
    do_action(8'd100, 8'hFF, 1'b0);
    render(0, 0, 3'b101);
    render(790, 300, 3'b101);
    do_action(8'd100, 8'hFF, 1'b0);
    render(0, 0, 3'b101);
    for (int i = 0; i < 5; i++) begin
      do_action(8'hFD, 8'hFF, 1'b0);
      render(0, 0, 3'b101);
    end

    // hit again, then recentre with the button while still tilted
    do_action(8'd100, 8'hFF, 1'b0);
    do_action(8'd100, 8'd100, 1'b1);
    render(0, 0, 3'b011);
    render(400, 300, 3'b011);

    // left wall clamp at zero
    while (mdl_x > 0) do_action(8'h9C, 8'hFF, 1'b0);
    do_action(8'h9C, 8'hFF, 1'b0);

    // reset between the two frames of an action discards the pending update
    accel_data_x = 8'd100;
    eof_pulse();
    apply_reset();
    do_action(8'd100, 8'hFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
